// File: rtl/rob_pkg.sv
// rob_pkg: reorder buffer sizing, instruction type codes and entry layout.
package rob_pkg;
  localparam int ROB_SIZE_BIT_DFLT = 3;
  localparam int ROB_TYPE_W = 2;
  typedef enum logic [ROB_TYPE_W-1:0] {
    ROB_TYPE_REG    = 2'd0,
    ROB_TYPE_STORE  = 2'd1,
    ROB_TYPE_BRANCH = 2'd2,
    ROB_TYPE_EXIT   = 2'd3
  } rob_type_e;
  typedef struct packed {
    logic        busy;
    logic        ready;
    rob_type_e   kind;
    logic [4:0]  rd;
    logic [31:0] value;
    logic        pred_taken;
    logic [31:0] alt_pc;
  } rob_entry_t;
endpackage

// File: rtl/rob.sv
// rob: in-order retirement buffer with CDB capture, operand bypass and branch flush.
module rob
  import rob_pkg::*;
#(
  parameter int ROB_SIZE_BIT = ROB_SIZE_BIT_DFLT
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  output logic                    rob_full,
  input  logic                    inst_input,
  input  logic [ROB_TYPE_W-1:0]   inst_type,
  input  logic [4:0]              inst_rd,
  input  logic                    inst_ready,
  input  logic [31:0]             inst_value,
  input  logic                    inst_pred_taken,
  input  logic [31:0]             inst_alt_pc,
  output logic [ROB_SIZE_BIT-1:0] tail_id,
  input  logic [ROB_SIZE_BIT-1:0] q1_id,
  input  logic [ROB_SIZE_BIT-1:0] q2_id,
  output logic                    q1_ready,
  output logic                    q2_ready,
  output logic [31:0]             q1_value,
  output logic [31:0]             q2_value,
  input  logic                    rs_fi,
  input  logic [31:0]             rs_value,
  input  logic [ROB_SIZE_BIT-1:0] rs_rob_id,
  input  logic                    lsb_fi,
  input  logic [31:0]             lsb_value,
  input  logic [ROB_SIZE_BIT-1:0] lsb_rob_id,
  output logic                    commit_reg_en,
  output logic [4:0]              commit_rd,
  output logic [31:0]             commit_value,
  output logic [ROB_SIZE_BIT-1:0] commit_rob_id,
  output logic                    commit_store_en,
  output logic                    rob_clear,
  output logic [31:0]             clear_pc,
  output logic                    halt
);
  localparam int N = 1 << ROB_SIZE_BIT;
  localparam logic [ROB_SIZE_BIT:0] FULL = (ROB_SIZE_BIT+1)'(N);
  localparam logic [ROB_SIZE_BIT:0] NEAR = (ROB_SIZE_BIT+1)'(N-1);
  rob_entry_t                r_ent [N];
  logic [ROB_SIZE_BIT-1:0]   r_head, r_tail;
  logic [ROB_SIZE_BIT:0]     r_count;
  rob_entry_t                w_head_e;
  logic                      w_fire, w_disp, w_mispred;
  logic [ROB_SIZE_BIT-1:0]   w_qid [2];
  logic                      w_qr [2];
  logic [31:0]               w_qv [2];
  assign w_head_e  = r_ent[r_head];
  assign w_fire    = w_head_e.busy && w_head_e.ready && rdy_in && !rob_clear && !halt;
  assign w_disp    = inst_input && rdy_in && !rob_clear;
  assign w_mispred = w_head_e.kind == ROB_TYPE_BRANCH && w_head_e.value[0] != w_head_e.pred_taken;
  assign rob_full  = (r_count == FULL) || (r_count == NEAR && inst_input && !w_fire);
  assign tail_id   = r_tail;
  assign w_qid[0]  = q1_id;
  assign w_qid[1]  = q2_id;
  // A stored value beats the live CDB; rs beats lsb on the live bus.
  for (genvar q = 0; q < 2; q++) begin : g_query
    assign w_qr[q] = r_ent[w_qid[q]].ready || (rs_fi && rs_rob_id == w_qid[q])
                     || (lsb_fi && lsb_rob_id == w_qid[q]);
    assign w_qv[q] = r_ent[w_qid[q]].ready ? r_ent[w_qid[q]].value
                   : (rs_fi && rs_rob_id == w_qid[q]) ? rs_value : lsb_value;
  end
  assign q1_ready = w_qr[0];
  assign q2_ready = w_qr[1];
  assign q1_value = w_qv[0];
  assign q2_value = w_qv[1];
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      for (int i = 0; i < N; i++) r_ent[i] <= '0;
      commit_reg_en   <= 1'b0;
      commit_store_en <= 1'b0;
      commit_rd       <= '0;
      commit_value    <= '0;
      commit_rob_id   <= '0;
      rob_clear       <= 1'b0;
      clear_pc        <= '0;
      halt            <= 1'b0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        r_head          <= '0;
        r_tail          <= '0;
        r_count         <= '0;
        for (int i = 0; i < N; i++) r_ent[i] <= '0;
        commit_reg_en   <= 1'b0;
        commit_store_en <= 1'b0;
        commit_rd       <= '0;
        commit_value    <= '0;
        commit_rob_id   <= '0;
        rob_clear       <= 1'b0;
        clear_pc        <= '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (r_ent[i].busy && !r_ent[i].ready) begin
            if (rs_fi && rs_rob_id == ROB_SIZE_BIT'(i)) begin
              r_ent[i].value <= rs_value;
              r_ent[i].ready <= 1'b1;
            end else if (lsb_fi && lsb_rob_id == ROB_SIZE_BIT'(i)) begin
              r_ent[i].value <= lsb_value;
              r_ent[i].ready <= 1'b1;
            end
          end
        end
        if (w_fire) begin
          r_ent[r_head].busy <= 1'b0;
          r_head             <= r_head + 1'b1;
        end
        // Written last so a slot freed by this cycle's commit can be refilled.
        if (w_disp) begin
          r_ent[r_tail] <= '{busy: 1'b1,
                             ready: inst_ready || inst_type == ROB_TYPE_STORE || inst_type == ROB_TYPE_EXIT,
                             kind: rob_type_e'(inst_type), rd: inst_rd, value: inst_value,
                             pred_taken: inst_pred_taken, alt_pc: inst_alt_pc};
          r_tail        <= r_tail + 1'b1;
        end
        r_count         <= r_count + (ROB_SIZE_BIT+1)'(w_disp) - (ROB_SIZE_BIT+1)'(w_fire);
        commit_reg_en   <= w_fire && w_head_e.kind == ROB_TYPE_REG;
        commit_store_en <= w_fire && w_head_e.kind == ROB_TYPE_STORE;
        commit_rd       <= w_fire ? w_head_e.rd : '0;
        commit_value    <= w_fire ? w_head_e.value : '0;
        commit_rob_id   <= w_fire ? r_head : '0;
        rob_clear       <= w_fire && w_mispred;
        clear_pc        <= (w_fire && w_mispred) ? w_head_e.alt_pc : '0;
        halt            <= halt || (w_fire && w_head_e.kind == ROB_TYPE_EXIT);
      end
    end
  end
endmodule

// File: tb/tb_rob.sv
// tb_rob: scoreboard bench for rob; expected commits are queued at stimulus time.
module tb_rob;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        rob_full;
  logic        inst_input = 1'b0;
  logic [1:0]  inst_type = '0;
  logic [4:0]  inst_rd = '0;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_value = '0;
  logic        inst_pred_taken = 1'b0;
  logic [31:0] inst_alt_pc = '0;
  logic [2:0]  tail_id;
  logic [2:0]  q1_id = '0, q2_id = '0;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_value, q2_value;
  logic        rs_fi = 1'b0;
  logic [31:0] rs_value = '0;
  logic [2:0]  rs_rob_id = '0;
  logic        lsb_fi = 1'b0;
  logic [31:0] lsb_value = '0;
  logic [2:0]  lsb_rob_id = '0;
  logic        commit_reg_en, commit_store_en, rob_clear, halt;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value, clear_pc;
  logic [2:0]  commit_rob_id;
  int          n_chk = 0, n_err = 0;
  typedef struct {logic st; logic [4:0] rd; logic [31:0] val; logic [2:0] id;} exp_t;
  exp_t sb[$];

  rob #(.ROB_SIZE_BIT(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_full(rob_full),
    .inst_input(inst_input), .inst_type(inst_type), .inst_rd(inst_rd),
    .inst_ready(inst_ready), .inst_value(inst_value), .inst_pred_taken(inst_pred_taken),
    .inst_alt_pc(inst_alt_pc), .tail_id(tail_id), .q1_id(q1_id), .q2_id(q2_id),
    .q1_ready(q1_ready), .q2_ready(q2_ready), .q1_value(q1_value), .q2_value(q2_value),
    .rs_fi(rs_fi), .rs_value(rs_value), .rs_rob_id(rs_rob_id), .lsb_fi(lsb_fi),
    .lsb_value(lsb_value), .lsb_rob_id(lsb_rob_id), .commit_reg_en(commit_reg_en),
    .commit_rd(commit_rd), .commit_value(commit_value), .commit_rob_id(commit_rob_id),
    .commit_store_en(commit_store_en), .rob_clear(rob_clear), .clear_pc(clear_pc), .halt(halt)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic void exp_reg(input logic [4:0] rd, input logic [31:0] v, input logic [2:0] id);
    sb.push_back('{1'b0, rd, v, id});
  endfunction

  function automatic void exp_st(input logic [2:0] id);
    sb.push_back('{1'b1, 5'd0, 32'd0, id});
  endfunction

  task automatic do_reset();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    inst_input = 1'b0;
    rs_fi = 1'b0;
    lsb_fi = 1'b0;
    repeat (2) tick();
    rst_in = 1'b0;
    tick();
  endtask

  task automatic disp(input logic [1:0] t, input logic [4:0] rd, input logic rdy,
                      input logic [31:0] v, input logic pt, input logic [31:0] alt, input int id);
    inst_input = 1'b1;
    inst_type = t;
    inst_rd = rd;
    inst_ready = rdy;
    inst_value = v;
    inst_pred_taken = pt;
    inst_alt_pc = alt;
    #1;
    check("tail_id", 32'(tail_id), 32'(id));
    tick();
    inst_input = 1'b0;
  endtask

  task automatic rs_done(input logic [2:0] id, input logic [31:0] v);
    rs_fi = 1'b1;
    rs_rob_id = id;
    rs_value = v;
    tick();
    rs_fi = 1'b0;
  endtask

  // Commit outputs are consumed once per clock with rdy_in high.
  always @(negedge clk_in) begin
    if (!rst_in && rdy_in && (commit_reg_en || commit_store_en)) begin
      if (sb.size() == 0) check("cmt_extra", {30'd0, commit_reg_en, commit_store_en}, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("cmt_kind", {30'd0, commit_reg_en, commit_store_en}, e.st ? 32'd1 : 32'd2);
        check("cmt_id", 32'(commit_rob_id), 32'(e.id));
        if (!e.st) begin
          check("cmt_rd", 32'(commit_rd), 32'(e.rd));
          check("cmt_val", commit_value, e.val);
        end
      end
    end
  end

  initial begin
    do_reset();
    check("rst_full", 32'(rob_full), 0);
    check("rst_tail", 32'(tail_id), 0);
    check("rst_reg_en", 32'(commit_reg_en), 0);
    check("rst_clear", 32'(rob_clear), 0);
    check("rst_halt", 32'(halt), 0);
    // ready-at-dispatch REG
    exp_reg(5'd5, 32'h12, 3'd0);
    disp(2'd0, 5'd5, 1'b1, 32'h12, 1'b0, 32'd0, 0);
    repeat (4) tick();
    // same-cycle rs bypass on a query
    do_reset();
    disp(2'd0, 5'd6, 1'b0, 32'd0, 1'b0, 32'd0, 0);
    q1_id = 3'd0;
    #1;
    check("q1_pending", 32'(q1_ready), 0);
    rs_fi = 1'b1;
    rs_rob_id = 3'd0;
    rs_value = 32'hAB;
    exp_reg(5'd6, 32'hAB, 3'd0);
    #1;
    check("q1_byp_rdy", 32'(q1_ready), 1);
    check("q1_byp_val", q1_value, 32'hAB);
    tick();
    rs_fi = 1'b0;
    #1;
    check("q1_stored", q1_value, 32'hAB);
    repeat (4) tick();
    // fill to full, free one via lsb, wrap tail
    do_reset();
    for (int i = 0; i < 8; i++) begin
      inst_input = 1'b1;
      inst_type = 2'd0;
      inst_rd = 5'(i + 1);
      inst_ready = 1'b0;
      #1;
      check("fill_tail", 32'(tail_id), 32'(i));
      if (i == 6) check("full_at6", 32'(rob_full), 0);
      if (i == 7) check("full_at7", 32'(rob_full), 1);
      tick();
    end
    inst_input = 1'b0;
    #1;
    check("full_8", 32'(rob_full), 1);
    exp_reg(5'd1, 32'h500, 3'd0);
    lsb_fi = 1'b1;
    lsb_rob_id = 3'd0;
    lsb_value = 32'h500;
    q2_id = 3'd0;
    #1;
    check("q2_lsb_rdy", 32'(q2_ready), 1);
    check("q2_lsb_val", q2_value, 32'h500);
    tick();
    lsb_fi = 1'b0;
    tick();
    check("wrap_tail", 32'(tail_id), 0);
    check("full_freed", 32'(rob_full), 0);
    disp(2'd0, 5'd9, 1'b1, 32'h77, 1'b0, 32'd0, 0);
    for (int i = 1; i < 8; i++) begin
      exp_reg(5'(i + 1), 32'h100 + 32'(i), 3'(i));
      rs_done(3'(i), 32'h100 + 32'(i));
    end
    exp_reg(5'd9, 32'h77, 3'd0);
    repeat (12) tick();
    check("sb_drain1", 32'(sb.size()), 0);
    // mispredicted branch flushes a younger REG
    do_reset();
    disp(2'd2, 5'd0, 1'b0, 32'd0, 1'b1, 32'h100, 0);
    disp(2'd0, 5'd3, 1'b1, 32'h33, 1'b0, 32'd0, 1);
    rs_done(3'd0, 32'd0);
    for (int k = 0; k < 20 && !rob_clear; k++) tick();
    check("clear_hi", 32'(rob_clear), 1);
    check("clear_pc", clear_pc, 32'h100);
    tick();
    check("clear_lo", 32'(rob_clear), 0);
    check("flush_tail", 32'(tail_id), 0);
    check("flush_full", 32'(rob_full), 0);
    repeat (6) tick();
    // out-of-order completion retires in order
    do_reset();
    disp(2'd0, 5'd10, 1'b0, 32'd0, 1'b0, 32'd0, 0);
    disp(2'd0, 5'd11, 1'b0, 32'd0, 1'b0, 32'd0, 1);
    exp_reg(5'd10, 32'hA0, 3'd0);
    exp_reg(5'd11, 32'hB1, 3'd1);
    rs_done(3'd1, 32'hB1);
    tick();
    check("ooo_hold", 32'(commit_reg_en), 0);
    rs_done(3'd0, 32'hA0);
    repeat (5) tick();
    // stall mid-commit, then EXIT halts
    do_reset();
    exp_st(3'd0);
    disp(2'd1, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 0);
    exp_reg(5'd12, 32'hC, 3'd1);
    disp(2'd0, 5'd12, 1'b1, 32'hC, 1'b0, 32'd0, 1);
    disp(2'd3, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 2);
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_en", 32'(commit_reg_en), 1);
      check("stall_val", commit_value, 32'hC);
      check("stall_halt", 32'(halt), 0);
    end
    rdy_in = 1'b1;
    for (int k = 0; k < 20 && !halt; k++) tick();
    check("halt_set", 32'(halt), 1);
    disp(2'd0, 5'd13, 1'b1, 32'hD, 1'b0, 32'd0, 3);
    repeat (5) tick();
    check("halt_sticky", 32'(halt), 1);
    check("halt_no_cmt", 32'(commit_reg_en), 0);
    do_reset();
    check("halt_rst", 32'(halt), 0);
    check("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer for the out-of-order RV32 core.
- Allocates the ROB ids that dispatched instructions, RS and LSB use as dependency tags.
- Receives the two CDB channels (rs_*, lsb_*) and commits in program order to the register file and LSB.
- On a mispredicted branch, generates rob_clear and the redirect PC.

Parameters:
- ROB_SIZE_BIT, 3, log2 of entry count (8 entries).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- rdy_in  input  1  pause when low; all state frozen
- rob_full  output  1  no dispatch next cycle
- inst_input  input  1  dispatch valid from Decoder
- inst_type  input  2  0 REG, 1 STORE, 2 BRANCH, 3 EXIT
- inst_rd  input  5  destination register (REG only)
- inst_ready  input  1  value already known at dispatch
- inst_value  input  32  value when inst_ready
- inst_pred_taken  input  1  predicted direction (BRANCH)
- inst_alt_pc  input  32  redirect PC if prediction wrong
- tail_id  output  ROB_SIZE_BIT  id given to the current dispatch
- q1_id, q2_id  input  ROB_SIZE_BIT  operand tag queries
- q1_ready, q2_ready  output  1  tag's value available
- q1_value, q2_value  output  32  that value
- rs_fi  input  1  ALU result valid
- rs_value  input  32  ALU result; for BRANCH, bit0 = actual taken
- rs_rob_id  input  ROB_SIZE_BIT  ALU result tag
- lsb_fi  input  1  LSB result valid
- lsb_value  input  32  LSB result value
- lsb_rob_id  input  ROB_SIZE_BIT  LSB result tag
- commit_reg_en  output  1  write register file
- commit_rd  output  5  destination register
- commit_value  output  32  write data
- commit_rob_id  output  ROB_SIZE_BIT  tag retired (regfile clears its dependency if equal)
- commit_store_en  output  1  LSB may perform the store with tag commit_rob_id
- rob_clear  output  1  flush pulse to all units
- clear_pc  output  32  fetch redirect target
- halt  output  1  EXIT committed

Behaviour:
- Circular buffer with head, tail and count. Per-entry fields: busy, ready, type, rd, value, pred_taken, alt_pc.
- Reset, and any rdy_in cycle with rob_clear=1: head=tail=count=0, all busy/ready=0. All outputs 0 except halt.
- halt is cleared only by reset and is sticky.
- rob_full = (count==2^ROB_SIZE_BIT) || (count==2^ROB_SIZE_BIT-1 && inst_input && !commit_fire).
- Dispatch (inst_input && rdy_in && !rob_clear):
  - Write entry tail; tail wraps modulo size.
  - tail_id is combinational = tail.
  - STORE and EXIT entries are ready at dispatch. Otherwise ready = inst_ready.
- CDB:
  - Each cycle, an entry that is busy, not ready, and tag-matches rs_rob_id (rs_fi) or lsb_rob_id (lsb_fi) latches the value and sets ready.
  - If both channels match the same entry, rs wins (must not occur).
- Queries are combinational. Priority:
  1. Entry already ready.
  2. Same-cycle rs_fi match.
  3. lsb_fi match.
  4. Otherwise q_ready=0.
  - q_value is don't-care when not ready.
- Commit: commit_fire = head busy && head ready && rdy_in && !rob_clear. At most one commit per cycle; head advances. All commit outputs are registered and valid for exactly one cycle after the fire:
  - REG: commit_reg_en=1 with rd/value/rob_id. rd=0 still asserts en; the regfile ignores x0.
  - STORE: commit_store_en=1, commit_rob_id.
  - BRANCH, value[0]==pred_taken: retire silently.
  - BRANCH mismatch: next cycle rob_clear=1 for one cycle and clear_pc=alt_pc. The following cycle the buffer is empty.
  - EXIT: halt=1. No further commits.
- Simultaneous dispatch and commit: count unchanged. Dispatch into a slot freed the same cycle is legal only via the rob_full rule.
- rdy_in low: no pointer, entry, or output register changes. Pulses extend until rdy_in is high.

Decomposition:
- Config.v holds ROB_SIZE_BIT, ROB type codes (ROB_TYPE_REG/STORE/BRANCH/EXIT) and their width.
- No sub-module is needed. The query/bypass mux may be a generate block.

Test Plan:
- Reset, then dispatch REG rd=5 inst_ready=1 value=0x12 → tail_id=0; next cycle commit_reg_en=1, rd=5, value=0x12, rob_id=0.
- Dispatch REG id0 not ready; query q1_id=0 while rs_fi, rs_rob_id=0, rs_value=0xAB → q1_ready=1, q1_value=0xAB same cycle; commit one cycle later.
- Dispatch 8 unready entries → rob_full high after the 7th dispatch with inst_input; lsb_fi for id0 → commit frees one slot, tail wraps to 0.
- BRANCH pred_taken=1, alt_pc=0x100, rs_value=0 → one-cycle rob_clear, clear_pc=0x100, then count=0 and a younger REG never commits.
- Out-of-order completion: ids 0,1 dispatched, id1 completes first → commits strictly id0 then id1.
- rdy_in low for 3 cycles mid-commit → outputs held, no extra commit; EXIT commit → halt=1 persists until rst_in.
